// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between a PLL lock sequencer and its controller.
// The sequencer uses the slave view; whoever requests bring-up and supplies LOCK uses master.
interface pll_lock_sequencer_if;
  logic       START;
  logic       LOCK;
  logic       PLL_EN;
  logic       CLK_GATE_EN;
  logic       READY;
  logic       FAIL;
  logic       LOSS_OF_LOCK;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;

  modport master (
    output START,
    output LOCK,
    input  PLL_EN,
    input  CLK_GATE_EN,
    input  READY,
    input  FAIL,
    input  LOSS_OF_LOCK,
    input  RETRY_CNT,
    input  STATE
  );

  modport slave (
    input  START,
    input  LOCK,
    output PLL_EN,
    output CLK_GATE_EN,
    output READY,
    output FAIL,
    output LOSS_OF_LOCK,
    output RETRY_CNT,
    output STATE
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock sequencer: power-down hold, enable, lock wait with timeout,
// stability window, bounded retries and loss-of-lock recovery. All outputs are flops.
module pll_lock_sequencer #(
  parameter int PWRDN_CYCLES  = 4,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  pll_lock_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRDN     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAILED    = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(PWRDN_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  // Saturating so a mis-set MAX_RETRIES can never wrap the counter back to zero.
  function automatic logic [3:0] retry_inc(input logic [3:0] r);
    return (r == 4'hF) ? r : r + 4'd1;
  endfunction

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry, retry_nxt;
  logic             attempt_fail;
  logic             loss_nxt;

  logic pll_en_q;
  logic run_q;
  logic fail_q;
  logic loss_q;

  // LOCK synchronizer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.LOCK};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Next-state, counter and retry decisions
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    retry_nxt    = retry;
    loss_nxt     = 1'b0;
    attempt_fail = 1'b0;

    if (!bus.START) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_PWRDN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
        ST_PWRDN: begin
          if (cnt == PWRDN_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still counts as a lock.
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            attempt_fail = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_PWRDN;
            cnt_nxt   = '0;
            loss_nxt  = 1'b1;
          end
        end
        ST_FAILED: begin
          state_nxt = ST_FAILED;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase

      if (attempt_fail) begin
        cnt_nxt = '0;
        if (retry == RETRY_LIMIT) begin
          state_nxt = ST_FAILED;
        end else begin
          state_nxt = ST_PWRDN;
          retry_nxt = retry_inc(retry);
        end
      end
    end
  end

  // State and registered outputs, decoded from the next state so they
  // change on the same edge as the state they describe
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      retry    <= '0;
      pll_en_q <= 1'b0;
      run_q    <= 1'b0;
      fail_q   <= 1'b0;
      loss_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      retry    <= retry_nxt;
      pll_en_q <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_STABLE) ||
                  (state_nxt == ST_RUN);
      run_q    <= (state_nxt == ST_RUN);
      fail_q   <= (state_nxt == ST_FAILED);
      loss_q   <= loss_nxt;
    end
  end

  assign bus.PLL_EN       = pll_en_q;
  assign bus.CLK_GATE_EN  = run_q;
  assign bus.READY        = run_q;
  assign bus.FAIL         = fail_q;
  assign bus.LOSS_OF_LOCK = loss_q;
  assign bus.RETRY_CNT    = retry;
  assign bus.STATE        = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Cycle-accurate bench for pll_lock_sequencer: per-edge vector tables checked
// through a scoreboard queue, plus a hand-written asynchronous reset check.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int PWRDN_CYCLES  = 4;
  localparam int LOCK_TIMEOUT  = 16;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int SYNC_STAGES   = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PWRDN  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAILED = 3'd5;

  // One record per clock edge: inputs sampled at that edge, outputs expected after it.
  typedef struct {
    int         tag;
    logic       start;
    logic       lock;
    logic [2:0] st;
    logic [3:0] retry;
    logic       loss;
  } vec_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .PWRDN_CYCLES (PWRDN_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #12.5 CLK = ~CLK;

  vec_t        tbl[$];
  logic [11:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void add(input int n, input int tag, input logic s, input logic l,
                              input logic [2:0] st, input logic [3:0] r, input logic loss);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.tag = tag; v.start = s; v.lock = l; v.st = st; v.retry = r; v.loss = loss;
      tbl.push_back(v);
    end
  endfunction

  // {STATE, PLL_EN, CLK_GATE_EN, READY, FAIL, LOSS_OF_LOCK, RETRY_CNT}
  function automatic logic [11:0] exp_word(input logic [2:0] st, input logic [3:0] r,
                                           input logic loss);
    logic en, run, fl;
    en  = (st == S_WAIT) || (st == S_STABLE) || (st == S_RUN);
    run = (st == S_RUN);
    fl  = (st == S_FAILED);
    return {st, en, run, run, fl, loss, r};
  endfunction

  function automatic logic [11:0] actual();
    return {bus.STATE, bus.PLL_EN, bus.CLK_GATE_EN, bus.READY, bus.FAIL,
            bus.LOSS_OF_LOCK, bus.RETRY_CNT};
  endfunction

  function automatic string fmt(input logic [11:0] w);
    return $sformatf("st=%0d pll_en=%b gate=%b ready=%b fail=%b loss=%b retry=%0d",
                     w[11:9], w[8], w[7], w[6], w[5], w[4], w[3:0]);
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  // Drive each record, queue its expectation, compare just after the edge.
  task automatic run_table();
    logic [11:0] exp;
    for (int i = 0; i < tbl.size(); i++) begin
      bus.START = tbl[i].start;
      bus.LOCK  = tbl[i].lock;
      sb_q.push_back(exp_word(tbl[i].st, tbl[i].retry, tbl[i].loss));
      @(posedge CLK);
      #1;
      exp = sb_q.pop_front();
      check($sformatf("test%0d_vec%0d", tbl[i].tag, i), actual(), exp);
    end
    tbl.delete();
  endtask

  // From IDLE with START rising: 4 PWRDN, lock first sampled on the 8th edge, RUN 10 edges later.
  function automatic void add_nominal(input int tag);
    add(4, tag, 1'b1, 1'b0, S_PWRDN,  4'd0, 1'b0);
    add(3, tag, 1'b1, 1'b0, S_WAIT,   4'd0, 1'b0);
    add(2, tag, 1'b1, 1'b1, S_WAIT,   4'd0, 1'b0);
    add(8, tag, 1'b1, 1'b1, S_STABLE, 4'd0, 1'b0);
    add(3, tag, 1'b1, 1'b1, S_RUN,    4'd0, 1'b0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.START = 1'b0;
    bus.LOCK  = 1'b0;
    RESET     = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", actual(), 12'h000);
    RESET = 1'b0;

    // 1: nominal bring-up
    add(2, 1, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    add_nominal(1);

    // 4: LOCK low for 3 samples in RUN, then relock
    add(2, 4, 1'b1, 1'b0, S_RUN,    4'd0, 1'b0);
    add(1, 4, 1'b1, 1'b0, S_PWRDN,  4'd0, 1'b1);
    add(3, 4, 1'b1, 1'b1, S_PWRDN,  4'd0, 1'b0);
    add(1, 4, 1'b1, 1'b1, S_WAIT,   4'd0, 1'b0);
    add(8, 4, 1'b1, 1'b1, S_STABLE, 4'd0, 1'b0);
    add(2, 4, 1'b1, 1'b1, S_RUN,    4'd0, 1'b0);

    // 6: shutdown from RUN with LOCK still high
    add(3, 6, 1'b0, 1'b1, S_IDLE, 4'd0, 1'b0);

    // 3: one-cycle LOCK glitch inside the stability window
    add(3, 3, 1'b0, 1'b0, S_IDLE,   4'd0, 1'b0);
    add(4, 3, 1'b1, 1'b0, S_PWRDN,  4'd0, 1'b0);
    add(2, 3, 1'b1, 1'b1, S_WAIT,   4'd0, 1'b0);
    add(5, 3, 1'b1, 1'b1, S_STABLE, 4'd0, 1'b0);
    add(1, 3, 1'b1, 1'b0, S_STABLE, 4'd0, 1'b0);
    add(1, 3, 1'b1, 1'b1, S_STABLE, 4'd0, 1'b0);
    add(4, 3, 1'b1, 1'b1, S_PWRDN,  4'd1, 1'b0);
    add(1, 3, 1'b1, 1'b1, S_WAIT,   4'd1, 1'b0);
    add(8, 3, 1'b1, 1'b1, S_STABLE, 4'd1, 1'b0);
    add(2, 3, 1'b1, 1'b1, S_RUN,    4'd0, 1'b0);

    // 2: LOCK never comes: three 16-cycle enable windows, then FAILED
    add(3, 2, 1'b0, 1'b0, S_IDLE, 4'd0, 1'b0);
    for (int r = 0; r <= MAX_RETRIES; r++) begin
      add(PWRDN_CYCLES, 2, 1'b1, 1'b0, S_PWRDN, 4'(r), 1'b0);
      add(LOCK_TIMEOUT, 2, 1'b1, 1'b0, S_WAIT,  4'(r), 1'b0);
    end
    add(3, 2, 1'b1, 1'b0, S_FAILED, 4'(MAX_RETRIES), 1'b0);
    add(1, 2, 1'b0, 1'b0, S_IDLE,   4'd0, 1'b0);

    // 5 lead-in: bring up into WAIT_LOCK with no lock yet
    add(1, 5, 1'b0, 1'b0, S_IDLE,  4'd0, 1'b0);
    add(4, 5, 1'b1, 1'b0, S_PWRDN, 4'd0, 1'b0);
    add(3, 5, 1'b1, 1'b0, S_WAIT,  4'd0, 1'b0);
    run_table();

    // 5: asynchronous reset pulse between edges while PLL_EN is high
    check("pre_reset_wait", actual(), exp_word(S_WAIT, 4'd0, 1'b0));
    #5 RESET = 1'b1;
    #1 check("async_reset_outputs", actual(), 12'h000);
    #2 RESET = 1'b0;

    add_nominal(5);
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
